alu_dispatch: RTL

Control-unit-side issuer for the ALU operand/result handshake. It accepts one operation at a time from decode, presents operands and opcode to the ALU bus, and holds them across the ALU sampling window. It captures the ALU result and flags on the ALU's ready pulse and returns them to writeback/branch logic over a valid/ready response port. It also detects illegal opcodes and a stalled ALU.

---
 rtl/alu_dispatch.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_dispatch.sv
// Issues one operation at a time from decode to the ALU operand bus, holds the bus
// through the ALU sampling window, and returns the captured result/flags on a valid/ready port.
module alu_dispatch #(
    parameter int TIMEOUT = 8
) (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic [31:0] req_dat1,
    input  logic [31:0] req_dat2,
    input  logic [4:0]  req_tag,
    output logic [31:0] ALU_dat1,
    output logic [31:0] ALU_dat2,
    output logic [5:0]  Instruction_from_CU,
    input  logic        ALU_accept,
    input  logic        ALU_ready,
    input  logic [31:0] ALU_out,
    input  logic        ALU_overflow,
    input  logic        ALU_con_met,
    input  logic        ALU_zero,
    input  logic        ALU_err,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_tag,
    output logic        rsp_overflow,
    output logic        rsp_con_met,
    output logic        rsp_zero,
    output logic        rsp_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_ACC, WAIT_RDY, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    op_q, op_d;
    logic [31:0]   dat1_q, dat1_d;
    logic [31:0]   dat2_q, dat2_d;
    logic [4:0]    tag_q, tag_d;

    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [5:0]    instr_q, instr_d;
    logic [31:0]   alu_dat1_q, alu_dat1_d;
    logic [31:0]   alu_dat2_q, alu_dat2_d;
    logic [31:0]   rsp_result_q, rsp_result_d;
    logic [4:0]    rsp_tag_q, rsp_tag_d;
    logic          rsp_overflow_q, rsp_overflow_d;
    logic          rsp_con_met_q, rsp_con_met_d;
    logic          rsp_zero_q, rsp_zero_d;
    logic          rsp_err_q, rsp_err_d;
    logic          bus_drive;

    function automatic logic is_legal(input logic [5:0] op);
        return (op >= 6'd4 && op <= 6'd9) || op == 6'd18 || op == 6'd19 ||
               (op >= 6'd21 && op <= 6'd36);
    endfunction

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        dat1_d         = dat1_q;
        dat2_d         = dat2_q;
        tag_d          = tag_q;
        rsp_result_d   = rsp_result_q;
        rsp_tag_d      = rsp_tag_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_con_met_d  = rsp_con_met_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_err_d      = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d   = req_opcode;
                    dat1_d = req_dat1;
                    dat2_d = req_dat2;
                    tag_d  = req_tag;
                    if (is_legal(req_opcode)) begin
                        state_d = WAIT_ACC;
                        cnt_d   = '0;
                    end else begin
                        // Illegal op never reaches the ALU; answer with an error directly.
                        state_d        = RESP;
                        rsp_result_d   = '0;
                        rsp_overflow_d = 1'b0;
                        rsp_con_met_d  = 1'b0;
                        rsp_zero_d     = 1'b0;
                        rsp_err_d      = 1'b1;
                        rsp_tag_d      = req_tag;
                    end
                end
            end
            WAIT_ACC: begin
                if (ALU_accept) begin
                    state_d = WAIT_RDY;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = RESP;
                    rsp_result_d   = '0;
                    rsp_overflow_d = 1'b0;
                    rsp_con_met_d  = 1'b0;
                    rsp_zero_d     = 1'b0;
                    rsp_err_d      = 1'b1;
                    rsp_tag_d      = tag_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_RDY: begin
                // A ready pulse in the final counted cycle still beats the timeout.
                if (ALU_ready) begin
                    state_d        = RESP;
                    rsp_result_d   = ALU_out;
                    rsp_overflow_d = ALU_overflow;
                    rsp_con_met_d  = ALU_con_met;
                    rsp_zero_d     = ALU_zero;
                    rsp_err_d      = ALU_err;
                    rsp_tag_d      = tag_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = RESP;
                    rsp_result_d   = '0;
                    rsp_overflow_d = 1'b0;
                    rsp_con_met_d  = 1'b0;
                    rsp_zero_d     = 1'b0;
                    rsp_err_d      = 1'b1;
                    rsp_tag_d      = tag_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        bus_drive   = (state_d == WAIT_ACC) || (state_d == WAIT_RDY);
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        instr_d     = bus_drive ? op_d : 6'd0;
        alu_dat1_d  = bus_drive ? dat1_d : 32'd0;
        alu_dat2_d  = bus_drive ? dat2_d : 32'd0;
    end

    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            op_q           <= '0;
            dat1_q         <= '0;
            dat2_q         <= '0;
            tag_q          <= '0;
            req_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            instr_q        <= '0;
            alu_dat1_q     <= '0;
            alu_dat2_q     <= '0;
            rsp_result_q   <= '0;
            rsp_tag_q      <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_con_met_q  <= 1'b0;
            rsp_zero_q     <= 1'b0;
            rsp_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            dat1_q         <= dat1_d;
            dat2_q         <= dat2_d;
            tag_q          <= tag_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            instr_q        <= instr_d;
            alu_dat1_q     <= alu_dat1_d;
            alu_dat2_q     <= alu_dat2_d;
            rsp_result_q   <= rsp_result_d;
            rsp_tag_q      <= rsp_tag_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_con_met_q  <= rsp_con_met_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_err_q      <= rsp_err_d;
        end
    end

    assign req_ready           = req_ready_q;
    assign rsp_valid           = rsp_valid_q;
    assign Instruction_from_CU = instr_q;
    assign ALU_dat1            = alu_dat1_q;
    assign ALU_dat2            = alu_dat2_q;
    assign rsp_result          = rsp_result_q;
    assign rsp_tag             = rsp_tag_q;
    assign rsp_overflow        = rsp_overflow_q;
    assign rsp_con_met         = rsp_con_met_q;
    assign rsp_zero            = rsp_zero_q;
    assign rsp_err             = rsp_err_q;

endmodule
